// File: rtl/conv_fprop3_acc_pkg.sv
// Shared types and constants for the conv_fprop3 window accumulator.
package conv_fprop3_acc_pkg;
    localparam int DIN_WIDTH_DEF  = 32;
    localparam int ACC_WIDTH_DEF  = 40;
    localparam int DOUT_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [DOUT_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH_DEF-1){1'b1}}};
    localparam logic [DOUT_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH_DEF-1){1'b0}}};
endpackage

// File: rtl/conv_fprop3_acc_32s_if.sv
// Product-in / result-out bus of the window accumulator.
interface conv_fprop3_acc_32s_if
    import conv_fprop3_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  win_len;
    logic [DOUT_WIDTH-1:0] bias;
    logic                  din_valid;
    logic [DIN_WIDTH-1:0]  din;
    logic                  din_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  busy;

    modport master (
        output start, win_len, bias, din_valid, din, dout_ready,
        input  din_ready, dout, dout_valid, busy
    );

    modport slave (
        input  start, win_len, bias, din_valid, din, dout_ready,
        output din_ready, dout, dout_valid, busy
    );
endinterface

// File: rtl/conv_fprop3_sat_relu.sv
// Narrows the wide accumulator to a saturated signed result.
// Defining CONV_FPROP3_ACC_RELU_EN additionally clamps negative results to zero.
module conv_fprop3_sat_relu
    import conv_fprop3_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [DOUT_WIDTH-1:0] res_o
);
    logic [ACC_WIDTH-DOUT_WIDTH:0] top_bits;
    logic                          fits;
    logic [DOUT_WIDTH-1:0]         sat;

    // Value fits when every bit above the result sign bit matches it.
    assign top_bits = acc_i[ACC_WIDTH-1:DOUT_WIDTH-1];
    assign fits     = (top_bits == '0) || (top_bits == '1);

    always_comb begin
        if (fits)                 sat = acc_i[DOUT_WIDTH-1:0];
        else if (acc_i[ACC_WIDTH-1]) sat = SAT_MIN;
        else                      sat = SAT_MAX;
    end

`ifdef CONV_FPROP3_ACC_RELU_EN
    assign res_o = sat[DOUT_WIDTH-1] ? '0 : sat;
`else
    assign res_o = sat;
`endif
endmodule

// File: rtl/conv_fprop3_acc_32s.sv
// Sums one window of 32s products plus a bias and emits one saturated result.
// Optional fused ReLU: CONV_FPROP3_ACC_RELU_EN (see conv_fprop3_sat_relu).
module conv_fprop3_acc_32s
    import conv_fprop3_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    conv_fprop3_acc_32s_if.slave  bus
);
    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [DOUT_WIDTH-1:0]  dout_q;

    logic [ACC_WIDTH-1:0]   bias_ext, din_ext, sum, sat_in;
    logic [DOUT_WIDTH-1:0]  sat_res;
    logic                   take_start, beat, last_beat;

    assign bias_ext   = {{(ACC_WIDTH-DOUT_WIDTH){bus.bias[DOUT_WIDTH-1]}}, bus.bias};
    assign din_ext    = {{(ACC_WIDTH-DIN_WIDTH){bus.din[DIN_WIDTH-1]}}, bus.din};
    assign sum        = acc_q + din_ext;
    assign take_start = (state_q == IDLE) && bus.start;
    assign beat       = (state_q == ACC) && bus.din_valid;
    assign last_beat  = beat && (cnt_q == CNT_WIDTH'(1));

    // One saturator serves both the empty-window bias path and the final beat.
    assign sat_in = (state_q == ACC) ? sum : bias_ext;

    conv_fprop3_sat_relu #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_sat (
        .acc_i (sat_in),
        .res_o (sat_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  state_q <= IDLE;
        else if (ce) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.win_len != '0) ? ACC : OUT;
            ACC:     if (last_beat) state_d = OUT;
            OUT:     if (bus.dout_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.din_ready  = (state_q == ACC);
        bus.dout_valid = (state_q == OUT);
        bus.busy       = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else if (ce) begin
            if (take_start) begin
                acc_q <= bias_ext;
                cnt_q <= bus.win_len;
                if (bus.win_len == '0) dout_q <= sat_res;
            end else if (beat) begin
                acc_q <= sum;
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                if (last_beat) dout_q <= sat_res;
            end
        end
    end

    assign bus.dout = dout_q;
endmodule

// File: tb/tb_conv_fprop3_acc_32s.sv
// Directed bench for conv_fprop3_acc_32s with hand-computed window results.
module tb_conv_fprop3_acc_32s;
    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   n_run  = 0;
    int   n_fail = 0;

    conv_fprop3_acc_32s_if bus ();

    conv_fprop3_acc_32s dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [15:0] len, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.win_len = len;
        bus.bias    = b;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.din_valid = 1'b1;
        bus.din       = d;
        tick();
        bus.din_valid = 1'b0;
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef CONV_FPROP3_ACC_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    logic [31:0] held;

    initial begin
        reset = 1'b0; ce = 1'b1;
        bus.start = 1'b0; bus.win_len = '0; bus.bias = '0;
        bus.din_valid = 1'b0; bus.din = '0; bus.dout_ready = 1'b1;
        #12;
        chk("rst_dout",   bus.dout, 32'd0);
        chk("rst_valid",  bus.dout_valid, 1'b0);
        chk("rst_ready",  bus.din_ready, 1'b0);
        chk("rst_busy",   bus.busy, 1'b0);
        reset = 1'b1;
        tick();

        // 1: basic window, back-to-back beats
        start_win(16'd3, 32'd10);
        chk("t1_ready", bus.din_ready, 1'b1);
        chk("t1_busy",  bus.busy, 1'b1);
        beat(32'd5);
        beat(-32'sd2);
        chk("t1_noval", bus.dout_valid, 1'b0);
        beat(32'd7);
        chk("t1_valid", bus.dout_valid, 1'b1);
        chk("t1_dout",  bus.dout, 32'd20);
        chk("t1_rdy0",  bus.din_ready, 1'b0);
        tick();
        chk("t1_idle",  bus.busy, 1'b0);
        chk("t1_vdrop", bus.dout_valid, 1'b0);

        // 2: bubbles between beats
        start_win(16'd4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat(32'd100);
            if (i < 3) begin
                tick();
                chk("t2_bubble", bus.dout_valid, 1'b0);
            end
        end
        chk("t2_valid", bus.dout_valid, 1'b1);
        chk("t2_dout",  bus.dout, 32'd400);
        tick();

        // 3: saturation both ways
        start_win(16'd2, 32'h7FFF_FFFF);
        beat(32'h7FFF_FFFF);
        beat(32'h7FFF_FFFF);
        chk("t3_satmax", bus.dout, 32'h7FFF_FFFF);
        tick();
        start_win(16'd2, 32'h8000_0000);
        beat(32'h8000_0000);
        beat(32'h8000_0000);
        chk("t3_satmin", bus.dout, relu(32'h8000_0000));
        tick();

        // 4: empty window and single negative beat; start on accept cycle ignored
        start_win(16'd0, -32'sd9);
        chk("t4_valid0", bus.dout_valid, 1'b1);
        chk("t4_dout0",  bus.dout, relu(-32'sd9));
        bus.start = 1'b1; bus.win_len = 16'd5;
        tick();
        bus.start = 1'b0;
        chk("t4_ignst",  bus.busy, 1'b0);
        start_win(16'd1, 32'd0);
        beat(-32'sd50);
        chk("t4_dout1",  bus.dout, relu(-32'sd50));
        tick();

        // 5: ce stall mid-window, stray starts, backpressure on result
        start_win(16'd3, 32'd1);
        beat(32'd1);
        ce = 1'b0; bus.din_valid = 1'b1; bus.din = 32'd1000;
        for (int i = 0; i < 3; i++) tick();
        bus.din_valid = 1'b0; ce = 1'b1;
        bus.start = 1'b1; bus.win_len = 16'd0; bus.bias = 32'd77;
        tick();
        bus.start = 1'b0;
        chk("t5_stall", bus.dout_valid, 1'b0);
        beat(32'd2);
        bus.dout_ready = 1'b0;
        beat(32'd3);
        chk("t5_dout", bus.dout, 32'd7);
        held = bus.dout;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            chk("t5_hold_v", bus.dout_valid, 1'b1);
            chk("t5_hold_d", bus.dout, held);
        end
        bus.start = 1'b0;
        ce = 1'b0; bus.dout_ready = 1'b1;
        tick();
        chk("t5_ce_hold", bus.dout_valid, 1'b1);
        ce = 1'b1;
        tick();
        chk("t5_accept", bus.dout_valid, 1'b0);

        // 6: async reset mid-window discards partial sum
        start_win(16'd4, 32'd0);
        beat(32'd11);
        beat(32'd12);
        reset = 1'b0;
        #1;
        chk("t6_busy",  bus.busy, 1'b0);
        chk("t6_ready", bus.din_ready, 1'b0);
        chk("t6_valid", bus.dout_valid, 1'b0);
        chk("t6_dout",  bus.dout, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        start_win(16'd1, 32'd0);
        beat(32'd3);
        chk("t6_new", bus.dout, 32'd3);
        chk("t6_newv", bus.dout_valid, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
